// File: rtl/tohost_monitor.sv
// tohost_monitor
// Watches core data-memory stores for a write to the tohost word. It
// reports pass, fail (with the failing test number) or timeout, and counts
// the cycles and instructions retired while the test is running.
//
// State table
//    state | meaning
//    RUN   | test running; counters advance and stores are watched
//    PASS  | tohost written with 1; terminal until reset
//    FAIL  | tohost written with an odd value other than 1; terminal
//    TMO   | TIMEOUT cycles in RUN without a verdict; terminal
//
// Ports
//    clk            single clock, rising edge
//    rst            synchronous active-low reset
//    wr_en          store strobe, one store per high cycle
//    wr_addr        store byte address
//    wr_be          store byte enables
//    wr_data        store data
//    retire         one instruction retired this cycle
//    done           pass | fail | timeout
//    pass           tohost written with 1
//    fail           tohost written with an odd value other than 1
//    timeout        TIMEOUT reached without a verdict
//    fail_test      wr_data[31:1] of the failing store
//    cycle_count    cycles spent in RUN (saturating)
//    retire_count   instructions retired in RUN (saturating)
//    ignored_count  tohost stores discarded (saturating)
module tohost_monitor #(
   parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
   parameter int          TIMEOUT     = 5000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [3:0]  wr_be,
   input  logic [31:0] wr_data,
   input  logic        retire,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic [30:0] fail_test,
   output logic [31:0] cycle_count,
   output logic [31:0] retire_count,
   output logic [7:0]  ignored_count
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      PASS = 2'd1,
      FAIL = 2'd2,
      TMO  = 2'd3
   } state_t;

   localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   state_t      state_q, state_d;
   logic [30:0] fail_test_q, fail_test_d;
   logic [31:0] cycle_q, cycle_d;
   logic [31:0] retire_q, retire_d;
   logic [7:0]  ignored_q, ignored_d;
   logic        pass_q, fail_q, timeout_q, done_q;

   logic hit;
   logic deciding;

   // Address match on the word only; masking keeps every address bit in use.
   assign hit      = wr_en && ((wr_addr & WORD_MASK) == (TOHOST_ADDR & WORD_MASK));
   assign deciding = hit && (wr_be == 4'hF) && wr_data[0];

   always_comb begin
      state_d     = state_q;
      fail_test_d = fail_test_q;
      cycle_d     = cycle_q;
      retire_d    = retire_q;
      ignored_d   = ignored_q;

      if (state_q == RUN) begin
         if (cycle_q != 32'hFFFF_FFFF) cycle_d = cycle_q + 32'd1;
         if (retire && (retire_q != 32'hFFFF_FFFF)) retire_d = retire_q + 32'd1;

         // A deciding store wins over a timeout landing on the same edge.
         if (deciding) begin
            if (wr_data == 32'd1) begin
               state_d = PASS;
            end else begin
               state_d     = FAIL;
               fail_test_d = wr_data[31:1];
            end
         end else begin
            if (hit && (ignored_q != 8'hFF)) ignored_d = ignored_q + 8'd1;
            if (cycle_q == TMO_LAST) state_d = TMO;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= RUN;
         fail_test_q <= '0;
         cycle_q     <= '0;
         retire_q    <= '0;
         ignored_q   <= '0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         timeout_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         fail_test_q <= fail_test_d;
         cycle_q     <= cycle_d;
         retire_q    <= retire_d;
         ignored_q   <= ignored_d;
         pass_q      <= (state_d == PASS);
         fail_q      <= (state_d == FAIL);
         timeout_q   <= (state_d == TMO);
         done_q      <= (state_d != RUN);
      end
   end

   assign done          = done_q;
   assign pass          = pass_q;
   assign fail          = fail_q;
   assign timeout       = timeout_q;
   assign fail_test     = fail_test_q;
   assign cycle_count   = cycle_q;
   assign retire_count  = retire_q;
   assign ignored_count = ignored_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// Bench for tohost_monitor: a per-cycle vector table on the default
// instance plus hand-written pass, saturation, timeout and collision
// sequences. dut_a uses the default TIMEOUT and dut_b uses TIMEOUT=8.
// Both instances share the same inputs.
module tb_tohost_monitor;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic        retire;

   logic        a_done, a_pass, a_fail, a_timeout;
   logic [30:0] a_fail_test;
   logic [31:0] a_cycle, a_retire;
   logic [7:0]  a_ign;

   logic        b_done, b_pass, b_fail, b_timeout;
   logic [30:0] b_fail_test;
   logic [31:0] b_cycle, b_retire;
   logic [7:0]  b_ign;

   int checks   = 0;
   int failures = 0;

   tohost_monitor dut_a (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
      .wr_data(wr_data), .retire(retire), .done(a_done), .pass(a_pass),
      .fail(a_fail), .timeout(a_timeout), .fail_test(a_fail_test),
      .cycle_count(a_cycle), .retire_count(a_retire), .ignored_count(a_ign)
   );

   tohost_monitor #(.TIMEOUT(8)) dut_b (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
      .wr_data(wr_data), .retire(retire), .done(b_done), .pass(b_pass),
      .fail(b_fail), .timeout(b_timeout), .fail_test(b_fail_test),
      .cycle_count(b_cycle), .retire_count(b_retire), .ignored_count(b_ign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        en;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
      logic        ret;
      logic        e_pass;
      logic        e_fail;
      logic        e_tmo;
      logic [30:0] e_ft;
      logic [7:0]  e_ign;
      logic [31:0] e_cyc;
      logic [31:0] e_ret;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample one time unit after the edge.
   task automatic step(input logic r, input logic en, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] data, input logic ret);
      rst     = r;
      wr_en   = en;
      wr_addr = addr;
      wr_be   = be;
      wr_data = data;
      retire  = ret;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic ret);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, ret);
   endtask

   initial begin
      //          rst en  addr          be    data          ret  pass fail tmo ft             ign    cyc    ret
      vecs[0]  = '{1'b0, 1'b1, 32'h1000, 4'hF, 32'h1,        1'b1, 1'b0, 1'b0, 1'b0, 31'd0,          8'd0, 32'd0, 32'd0};
      vecs[1]  = '{1'b1, 1'b1, 32'h1000, 4'hF, 32'h2,        1'b0, 1'b0, 1'b0, 1'b0, 31'd0,          8'd1, 32'd1, 32'd0};
      vecs[2]  = '{1'b1, 1'b1, 32'h1000, 4'h1, 32'h1,        1'b1, 1'b0, 1'b0, 1'b0, 31'd0,          8'd2, 32'd2, 32'd1};
      vecs[3]  = '{1'b1, 1'b1, 32'h1004, 4'hF, 32'h1,        1'b0, 1'b0, 1'b0, 1'b0, 31'd0,          8'd2, 32'd3, 32'd1};
      vecs[4]  = '{1'b1, 1'b0, 32'h1000, 4'hF, 32'h1,        1'b1, 1'b0, 1'b0, 1'b0, 31'd0,          8'd2, 32'd4, 32'd2};
      vecs[5]  = '{1'b1, 1'b1, 32'h1002, 4'hF, 32'h7,        1'b1, 1'b0, 1'b1, 1'b0, 31'd3,          8'd2, 32'd5, 32'd3};
      vecs[6]  = '{1'b1, 1'b1, 32'h1000, 4'hF, 32'h1,        1'b1, 1'b0, 1'b1, 1'b0, 31'd3,          8'd2, 32'd5, 32'd3};
      vecs[7]  = '{1'b1, 1'b1, 32'h1000, 4'hF, 32'h2,        1'b0, 1'b0, 1'b1, 1'b0, 31'd3,          8'd2, 32'd5, 32'd3};
      vecs[8]  = '{1'b0, 1'b1, 32'h1000, 4'hF, 32'h1,        1'b1, 1'b0, 1'b0, 1'b0, 31'd0,          8'd0, 32'd0, 32'd0};
      vecs[9]  = '{1'b1, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 31'd0,          8'd0, 32'd1, 32'd1};
      vecs[10] = '{1'b1, 1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 31'h7FFF_FFFF, 8'd0, 32'd2, 32'd1};
      vecs[11] = '{1'b0, 1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 31'd0,          8'd0, 32'd0, 32'd0};

      for (int i = 0; i < 12; i++) begin
         step(vecs[i].rst, vecs[i].en, vecs[i].addr, vecs[i].be, vecs[i].data, vecs[i].ret);
         chk($sformatf("v%0d pass", i),      32'(a_pass),      32'(vecs[i].e_pass));
         chk($sformatf("v%0d fail", i),      32'(a_fail),      32'(vecs[i].e_fail));
         chk($sformatf("v%0d timeout", i),   32'(a_timeout),   32'(vecs[i].e_tmo));
         chk($sformatf("v%0d done", i),      32'(a_done),
             32'(vecs[i].e_pass | vecs[i].e_fail | vecs[i].e_tmo));
         chk($sformatf("v%0d fail_test", i), 32'(a_fail_test), 32'(vecs[i].e_ft));
         chk($sformatf("v%0d ignored", i),   32'(a_ign),       32'(vecs[i].e_ign));
         chk($sformatf("v%0d cycles", i),    a_cycle,          vecs[i].e_cyc);
         chk($sformatf("v%0d retired", i),   a_retire,         vecs[i].e_ret);
      end

      // Pass: 10 retiring cycles, then the passing store also retires.
      step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      idle(10, 1'b1);
      chk("pre-pass pass", 32'(a_pass), 32'd0);
      chk("pre-pass cycles", a_cycle, 32'd10);
      step(1'b1, 1'b1, 32'h1000, 4'hF, 32'h1, 1'b1);
      chk("pass pass", 32'(a_pass), 32'd1);
      chk("pass done", 32'(a_done), 32'd1);
      chk("pass fail", 32'(a_fail), 32'd0);
      chk("pass retired", a_retire, 32'd11);
      chk("pass cycles", a_cycle, 32'd11);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h1000, 4'hF, 32'h7, 1'b1);
      chk("frozen cycles", a_cycle, 32'd11);
      chk("frozen retired", a_retire, 32'd11);
      chk("frozen pass", 32'(a_pass), 32'd1);
      chk("frozen fail", 32'(a_fail), 32'd0);
      chk("frozen fail_test", 32'(a_fail_test), 32'd0);

      // ignored_count saturates; a later passing store still decides.
      step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      for (int i = 0; i < 260; i++) step(1'b1, 1'b1, 32'h1000, 4'hF, 32'h0, 1'b0);
      chk("sat ignored", 32'(a_ign), 32'hFF);
      chk("sat done", 32'(a_done), 32'd0);
      chk("sat cycles", a_cycle, 32'd260);
      step(1'b1, 1'b1, 32'h1000, 4'hF, 32'h1, 1'b0);
      chk("sat then pass", 32'(a_pass), 32'd1);

      // Timeout on dut_b (TIMEOUT=8).
      step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      idle(7, 1'b0);
      chk("tmo early timeout", 32'(b_timeout), 32'd0);
      chk("tmo early cycles", b_cycle, 32'd7);
      idle(1, 1'b0);
      chk("tmo timeout", 32'(b_timeout), 32'd1);
      chk("tmo done", 32'(b_done), 32'd1);
      chk("tmo cycles", b_cycle, 32'd8);
      step(1'b1, 1'b1, 32'h1000, 4'hF, 32'h1, 1'b1);
      chk("tmo late pass", 32'(b_pass), 32'd0);
      chk("tmo late timeout", 32'(b_timeout), 32'd1);
      chk("tmo late cycles", b_cycle, 32'd8);
      chk("tmo late retired", b_retire, 32'd0);

      // Collision: passing store on the 8th RUN cycle wins over timeout.
      step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      idle(7, 1'b0);
      step(1'b1, 1'b1, 32'h1000, 4'hF, 32'h1, 1'b0);
      chk("coll pass", 32'(b_pass), 32'd1);
      chk("coll timeout", 32'(b_timeout), 32'd0);
      chk("coll cycles", b_cycle, 32'd8);
      idle(2, 1'b0);
      chk("coll held timeout", 32'(b_timeout), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
